// File: rtl/stall_flush_controller_pkg.sv
// Shared pipeline-control types and constants for the stall/flush controller
// and the CSR performance-counter block.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    FLUSH_PEND = 2'd2
  } ctrl_state_e;

  localparam int MEM_TIMEOUT_DEF = 16;
  localparam int PERF_CNT_W      = 32;

endpackage

// File: rtl/stall_flush_controller_if.sv
// Pipeline-control bundle: request inputs from hazard/EX/MEM, enables and
// status back to the pipeline.
interface stall_flush_controller_if #(
  parameter int N = pipeline_ctrl_pkg::PERF_CNT_W
);
  logic         hazard_stall_i;
  logic         branch_taken_i;
  logic         mem_req_i;
  logic         mem_ready_i;
  logic         pc_hold_o;
  logic         if_id_hold_o;
  logic         if_id_flush_o;
  logic         id_ex_bubble_o;
  logic         ex_mem_hold_o;
  logic         mem_wb_bubble_o;
  logic         mem_error_o;
  logic [N-1:0] stall_count_o;
  logic [N-1:0] flush_count_o;

  modport master (
    output hazard_stall_i, branch_taken_i, mem_req_i, mem_ready_i,
    input  pc_hold_o, if_id_hold_o, if_id_flush_o, id_ex_bubble_o,
    input  ex_mem_hold_o, mem_wb_bubble_o, mem_error_o,
    input  stall_count_o, flush_count_o
  );

  modport slave (
    input  hazard_stall_i, branch_taken_i, mem_req_i, mem_ready_i,
    output pc_hold_o, if_id_hold_o, if_id_flush_o, id_ex_bubble_o,
    output ex_mem_hold_o, mem_wb_bubble_o, mem_error_o,
    output stall_count_o, flush_count_o
  );
endinterface

// File: rtl/stall_flush_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/stall_flush_controller.sv
// Prioritised hold/flush/bubble generation for the 5-stage pipeline, with
// memory-wait FSM, pending-flush latch, timeout watchdog and perf counters.
module stall_flush_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int N           = PERF_CNT_W,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input logic                     clk,
  input logic                     reset,
  stall_flush_controller_if.slave bus
);
  localparam int            WW        = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  ctrl_state_e   state_q, state_d;
  logic          pend_flush_q, pend_flush_d;
  logic          mem_error_q, mem_error_d;
  logic [WW-1:0] wait_cnt;
  logic          pc_hold, if_id_hold, if_id_flush, id_ex_bubble, ex_mem_hold, mem_wb_bubble;

  always_comb begin
    state_d       = state_q;
    pend_flush_d  = pend_flush_q;
    mem_error_d   = mem_error_q;
    pc_hold       = 1'b0;
    if_id_hold    = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_hold   = 1'b0;
    mem_wb_bubble = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.mem_req_i && !bus.mem_ready_i) begin
          {pc_hold, if_id_hold, ex_mem_hold, mem_wb_bubble} = 4'b1111;
          state_d = MEM_WAIT;
        end else if (bus.branch_taken_i) begin
          // A taken branch squashes a simultaneous load-use stall: wrong path.
          {if_id_flush, id_ex_bubble} = 2'b11;
        end else if (bus.hazard_stall_i) begin
          {pc_hold, if_id_hold, id_ex_bubble} = 3'b111;
        end
      end
      MEM_WAIT, FLUSH_PEND: begin
        if (bus.mem_ready_i) begin
          if (pend_flush_q || bus.branch_taken_i) {if_id_flush, id_ex_bubble} = 2'b11;
          pend_flush_d = 1'b0;
          state_d      = RUN;
        end else begin
          {pc_hold, if_id_hold, ex_mem_hold, mem_wb_bubble} = 4'b1111;
          if (bus.branch_taken_i) pend_flush_d = 1'b1;
          if ((state_q == MEM_WAIT) && (wait_cnt == WAIT_LAST)) begin
            mem_error_d = 1'b1;
            state_d     = FLUSH_PEND;
          end
        end
      end
      default: state_d = RUN;
    endcase
    if (reset) begin
      {pc_hold, if_id_hold, if_id_flush, id_ex_bubble, ex_mem_hold, mem_wb_bubble} = 6'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      pend_flush_q <= 1'b0;
      mem_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_flush_q <= pend_flush_d;
      mem_error_q  <= mem_error_d;
    end
  end

  // wait_cnt sits at zero outside MEM_WAIT, so it is cleared on every entry.
  sat_counter #(.WIDTH(WW)) u_wait_cnt (
    .clk(clk), .reset(reset), .inc(state_q == MEM_WAIT), .clr(state_q != MEM_WAIT), .count(wait_cnt)
  );

  sat_counter #(.WIDTH(N)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(pc_hold), .clr(1'b0), .count(bus.stall_count_o)
  );

  sat_counter #(.WIDTH(N)) u_flush_cnt (
    .clk(clk), .reset(reset), .inc(if_id_flush), .clr(1'b0), .count(bus.flush_count_o)
  );

  assign bus.pc_hold_o       = pc_hold;
  assign bus.if_id_hold_o    = if_id_hold;
  assign bus.if_id_flush_o   = if_id_flush;
  assign bus.id_ex_bubble_o  = id_ex_bubble;
  assign bus.ex_mem_hold_o   = ex_mem_hold;
  assign bus.mem_wb_bubble_o = mem_wb_bubble;
  assign bus.mem_error_o     = mem_error_q;
endmodule

// File: tb/tb_stall_flush_controller.sv
// Directed bench for stall_flush_controller: single-cycle RUN vectors from a
// table, then hand-written memory-wait, pending-flush, timeout, reset and saturation sequences.
module tb_stall_flush_controller;
  // Output vector order: {pc_hold, if_id_hold, if_id_flush, id_ex_bubble, ex_mem_hold, mem_wb_bubble}
  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] STALL = 6'b110100;
  localparam logic [5:0] FLUSH = 6'b001100;
  localparam logic [5:0] HOLD  = 6'b110011;

  typedef struct {
    string      name;
    logic       hz, br, req, rdy;
    logic [5:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;

  always #5 clk = ~clk;

  stall_flush_controller_if #(.N(32)) bus1 ();
  stall_flush_controller_if #(.N(4))  bus2 ();

  stall_flush_controller #(.N(32), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  stall_flush_controller #(.N(4), .MEM_TIMEOUT(4)) dut_sat (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  function automatic logic [5:0] outs1();
    return {bus1.pc_hold_o, bus1.if_id_hold_o, bus1.if_id_flush_o,
            bus1.id_ex_bubble_o, bus1.ex_mem_hold_o, bus1.mem_wb_bubble_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // One cycle: drive at negedge, check the combinational outputs before the next posedge.
  task automatic step(input logic rs, input logic hz, input logic br, input logic req,
                      input logic rdy, input logic [5:0] exp, input string name);
    @(negedge clk);
    reset = rs;
    bus1.hazard_stall_i = hz;
    bus1.branch_taken_i = br;
    bus1.mem_req_i      = req;
    bus1.mem_ready_i    = rdy;
    #1;
    chk(name, {26'd0, outs1()}, {26'd0, exp});
    if (rs) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      exp_stall += int'(exp[5]);
      exp_flush += int'(exp[3]);
    end
  endtask

  // Registered state just after the edge that closes the last step.
  task automatic chk_state(input string name, input logic exp_err);
    @(posedge clk);
    #1;
    chk({name, "_stall_cnt"}, bus1.stall_count_o, exp_stall);
    chk({name, "_flush_cnt"}, bus1.flush_count_o, exp_flush);
    chk({name, "_mem_err"}, {31'd0, bus1.mem_error_o}, {31'd0, exp_err});
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{"idle",           1'b0, 1'b0, 1'b0, 1'b0, NONE};
    vecs[1] = '{"load_use",       1'b1, 1'b0, 1'b0, 1'b0, STALL};
    vecs[2] = '{"branch",         1'b0, 1'b1, 1'b0, 1'b0, FLUSH};
    vecs[3] = '{"branch_vs_stall",1'b1, 1'b1, 1'b0, 1'b0, FLUSH};
    vecs[4] = '{"mem_1cycle",     1'b0, 1'b0, 1'b1, 1'b1, NONE};
    vecs[5] = '{"mem_1cycle_hz",  1'b1, 1'b0, 1'b1, 1'b1, STALL};
    vecs[6] = '{"mem_1cycle_br",  1'b0, 1'b1, 1'b1, 1'b1, FLUSH};

    reset = 1'b1;
    bus1.hazard_stall_i = 1'b0; bus1.branch_taken_i = 1'b0;
    bus1.mem_req_i = 1'b0;      bus1.mem_ready_i = 1'b0;
    bus2.hazard_stall_i = 1'b0; bus2.branch_taken_i = 1'b0;
    bus2.mem_req_i = 1'b0;      bus2.mem_ready_i = 1'b0;

    // Outputs forced low during reset even with requests present.
    step(1, 1, 0, 0, 0, NONE, "rst_hz_forced0");
    step(1, 0, 1, 1, 0, NONE, "rst_mem_forced0");
    chk_state("reset", 1'b0);

    step(0, 1, 0, 0, 0, STALL, "load_use_only");
    chk_state("load_use", 1'b0);

    for (int i = 0; i < 7; i++) begin
      step(0, vecs[i].hz, vecs[i].br, vecs[i].req, vecs[i].rdy, vecs[i].exp, vecs[i].name);
    end
    chk_state("table", 1'b0);

    // Memory wait: ready low 3 cycles then high; hazard ignored while waiting.
    step(0, 0, 0, 1, 0, HOLD, "mw_req");
    step(0, 1, 0, 1, 0, HOLD, "mw_w0_hz_ignored");
    step(0, 0, 0, 1, 0, HOLD, "mw_w1");
    step(0, 0, 0, 1, 1, NONE, "mw_ready");
    chk_state("mw", 1'b0);
    step(0, 1, 0, 0, 0, STALL, "mw_back_in_run");

    // Pending flush: branch in 2nd wait cycle, ready in 4th (also the timeout cycle).
    step(0, 0, 0, 1, 0, HOLD,  "pf_req");
    step(0, 0, 0, 1, 0, HOLD,  "pf_w1");
    step(0, 0, 1, 1, 0, HOLD,  "pf_w2_branch");
    step(0, 0, 0, 1, 0, HOLD,  "pf_w3");
    step(0, 0, 0, 1, 1, FLUSH, "pf_ready_flush");
    chk_state("pf", 1'b0);
    step(0, 0, 0, 0, 0, NONE,  "pf_cleared");
    step(0, 0, 0, 1, 1, NONE,  "pf_no_second_flush");

    // Timeout: ready low for 6 cycles.
    step(0, 0, 0, 1, 0, HOLD, "to_req");
    step(0, 0, 0, 1, 0, HOLD, "to_w1");
    step(0, 0, 0, 1, 0, HOLD, "to_w2");
    step(0, 0, 0, 1, 0, HOLD, "to_w3");
    chk_state("to_before", 1'b0);
    step(0, 0, 0, 1, 0, HOLD, "to_w4");
    chk_state("to_after", 1'b1);
    step(0, 1, 0, 1, 0, HOLD, "to_fp_hz_ignored");
    step(0, 0, 0, 1, 1, NONE, "to_fp_ready");
    chk_state("to_ready", 1'b1);
    step(0, 1, 0, 0, 0, STALL, "to_back_in_run");

    // Reset mid-wait with a pending flush: both dropped.
    step(0, 0, 0, 1, 0, HOLD, "rw_req");
    step(0, 0, 1, 1, 0, HOLD, "rw_w1_branch");
    step(1, 0, 0, 1, 0, NONE, "rw_reset");
    chk_state("rw_reset", 1'b0);
    step(0, 0, 0, 0, 0, NONE,  "rw_idle");
    step(0, 0, 0, 1, 1, NONE,  "rw_no_stale_flush");
    step(0, 1, 0, 0, 0, STALL, "rw_run");
    chk_state("rw_end", 1'b0);

    // Saturation on the 4-bit instance: 20 stall cycles.
    chk("sat_start", {28'd0, bus2.stall_count_o}, 32'd0);
    @(negedge clk);
    bus2.hazard_stall_i = 1'b1;
    #1;
    chk("sat_pc_hold", {31'd0, bus2.pc_hold_o}, 32'd1);
    repeat (14) @(posedge clk);
    #1;
    chk("sat_14", {28'd0, bus2.stall_count_o}, 32'd14);
    repeat (6) @(posedge clk);
    #1;
    chk("sat_20", {28'd0, bus2.stall_count_o}, 32'd15);
    bus2.hazard_stall_i = 1'b0;
    @(posedge clk);
    #1;
    chk("sat_hold", {28'd0, bus2.stall_count_o}, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
